// File: rtl/ifetch_unit_if.sv
// Bundle of xbus request/response and decode-side handshake signals for ifetch_unit.
// master = fetch unit side, slave = ROM / decode / redirect source side.
`ifndef XADDRW
`define XADDRW 32
`endif
`ifndef XDATAW
`define XDATAW 32
`endif
`ifndef XBYTEC
`define XBYTEC 4
`endif

interface ifetch_unit_if;
    logic                 xbus_cs;
    logic                 xbus_we;
    logic [`XBYTEC-1:0]   xbus_be;
    logic [`XADDRW-1:0]   xbus_addr;
    logic [`XDATAW-1:0]   xbus_wdata;
    logic [`XDATAW-1:0]   xbus_rdata;
    logic                 redirect_valid;
    logic [`XADDRW-1:0]   redirect_pc;
    logic                 out_valid;
    logic                 out_ready;
    logic [`XDATAW-1:0]   out_inst;
    logic [`XADDRW-1:0]   out_pc;

    modport master (
        output xbus_cs, xbus_we, xbus_be, xbus_addr, xbus_wdata,
        output out_valid, out_inst, out_pc,
        input  xbus_rdata, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  xbus_cs, xbus_we, xbus_be, xbus_addr, xbus_wdata,
        input  out_valid, out_inst, out_pc,
        output xbus_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: issues word reads on xbus, captures the ROM's
// registered data a cycle later into a small queue, and hands it to decode.
`ifndef XADDRW
`define XADDRW 32
`endif
`ifndef XDATAW
`define XDATAW 32
`endif
`ifndef XBYTEC
`define XBYTEC 4
`endif

module ifetch_unit #(
    parameter logic [`XADDRW-1:0] RESET_PC = '0,
    parameter int                 QDEPTH   = 4
) (
    input  logic          clk,
    input  logic          rst,
    ifetch_unit_if.master bus
);
    localparam int            PTRW = $clog2(QDEPTH);
    localparam int            OCCW = PTRW + 1;
    localparam logic [OCCW:0] QLIM = (OCCW + 1)'(QDEPTH);

    logic [`XADDRW-1:0] r_fetchPc;
    logic [`XADDRW-1:0] r_inflPc;
    logic               r_infl;
    logic [OCCW-1:0]    r_occ;
    logic [PTRW-1:0]    r_head;
    logic [PTRW-1:0]    r_tail;
    logic [`XADDRW-1:0] r_qPc   [QDEPTH];
    logic [`XDATAW-1:0] r_qInst [QDEPTH];

    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic               w_outValid;
    logic [OCCW:0]      w_pending;
    logic [`XADDRW-1:0] w_redirPc;

    // Counting the in-flight word against capacity guarantees a free slot when it lands.
    assign w_pending  = {1'b0, r_occ} + {{OCCW{1'b0}}, r_infl};
    assign w_issue    = !rst && !bus.redirect_valid && (w_pending < QLIM);
    assign w_outValid = !rst && (r_occ != '0);
    assign w_pop      = w_outValid && bus.out_ready;
    assign w_push     = r_infl && !bus.redirect_valid;
    assign w_redirPc  = bus.redirect_pc & ~`XADDRW'(3);

    assign bus.xbus_cs    = w_issue;
    assign bus.xbus_we    = 1'b0;
    assign bus.xbus_be    = '1;
    assign bus.xbus_addr  = r_fetchPc;
    assign bus.xbus_wdata = '0;
    assign bus.out_valid  = w_outValid;
    assign bus.out_inst   = r_qInst[r_head];
    assign bus.out_pc     = r_qPc[r_head];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetchPc <= RESET_PC;
            r_inflPc  <= '0;
            r_infl    <= 1'b0;
            r_occ     <= '0;
            r_head    <= '0;
            r_tail    <= '0;
        end else begin
            r_infl <= w_issue;
            if (w_issue) begin
                r_fetchPc <= r_fetchPc + `XADDRW'(4);
                r_inflPc  <= r_fetchPc;
            end
            // A redirect never coincides with an issue, so it owns fetch_pc outright.
            if (bus.redirect_valid) begin
                r_fetchPc <= w_redirPc;
                r_occ     <= '0;
                r_head    <= '0;
                r_tail    <= '0;
            end else begin
                if (w_pop) begin
                    r_head <= r_head + 1'b1;
                end
                if (w_push) begin
                    r_tail <= r_tail + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_occ <= r_occ + 1'b1;
                    2'b01:   r_occ <= r_occ - 1'b1;
                    default: r_occ <= r_occ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_qPc[r_tail]   <= r_inflPc;
            r_qInst[r_tail] <= bus.xbus_rdata;
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: reset/stream, backpressure, redirects, wrap,
// and reset mid-operation against a ROM whose word at address A is A>>2.
`ifndef XADDRW
`define XADDRW 32
`endif
`ifndef XDATAW
`define XDATAW 32
`endif
`ifndef XBYTEC
`define XBYTEC 4
`endif

module tb_ifetch_unit;
    logic clk;
    logic rst;
    int   nCompared;
    int   nMismatched;
    int   nIssued;

    ifetch_unit_if bus ();

    ifetch_unit #(
        .RESET_PC (32'h0),
        .QDEPTH   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ROM: data for a request appears in the following cycle.
    always @(posedge clk) begin
        if (bus.xbus_cs) bus.xbus_rdata <= {2'b00, bus.xbus_addr[31:2]};
        else             bus.xbus_rdata <= 32'hDEAD_BEEF;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drives one cycle's inputs just after the edge and returns at mid-cycle for sampling.
    task automatic applyStimulus(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        @(posedge clk);
        #1;
        rst                = r;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.out_ready      = rdy;
        @(negedge clk);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        nCompared          = 0;
        nMismatched        = 0;
        nIssued            = 0;
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;

        $display("[TB] reset and stream");
        doReset();
        checkOutput("rst_cs", 32'(bus.xbus_cs), 32'd0);
        checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_we", 32'(bus.xbus_we), 32'd0);
        checkOutput("rst_be", 32'(bus.xbus_be), 32'hF);
        checkOutput("rst_wdata", bus.xbus_wdata, 32'h0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            checkOutput("s_cs", 32'(bus.xbus_cs), 32'd1);
            checkOutput("s_addr", bus.xbus_addr, 32'(4 * k));
            checkOutput("s_valid", 32'(bus.out_valid), 32'(k >= 2));
            if (k >= 2) begin
                checkOutput("s_pc", bus.out_pc, 32'(4 * (k - 2)));
                checkOutput("s_inst", bus.out_inst, 32'(k - 2));
            end
        end

        $display("[TB] backpressure");
        doReset();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
            if (bus.xbus_cs) nIssued++;
            checkOutput("bp_cs", 32'(bus.xbus_cs), 32'(k < 4));
            if (k < 4) checkOutput("bp_addr", bus.xbus_addr, 32'(4 * k));
            if (k >= 5) begin
                checkOutput("bp_valid", 32'(bus.out_valid), 32'd1);
                checkOutput("bp_head", bus.out_pc, 32'h0);
            end
        end
        checkOutput("bp_count", 32'(nIssued), 32'd4);
        for (int k = 8; k < 13; k++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            checkOutput("bp_rvalid", 32'(bus.out_valid), 32'd1);
            checkOutput("bp_rpc", bus.out_pc, 32'(4 * (k - 8)));
            checkOutput("bp_rinst", bus.out_inst, 32'(k - 8));
            checkOutput("bp_rcs", 32'(bus.xbus_cs), 32'(k != 8));
            if (k == 9) checkOutput("bp_raddr", bus.xbus_addr, 32'h10);
        end

        $display("[TB] redirect mid-stream");
        doReset();
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h103, 1'b0);
        checkOutput("rd_cs", 32'(bus.xbus_cs), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("rd_cs1", 32'(bus.xbus_cs), 32'd1);
        checkOutput("rd_addr1", bus.xbus_addr, 32'h100);
        checkOutput("rd_valid1", 32'(bus.out_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("rd_valid2", 32'(bus.out_valid), 32'd0);
        checkOutput("rd_addr2", bus.xbus_addr, 32'h104);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("rd_valid3", 32'(bus.out_valid), 32'd1);
        checkOutput("rd_pc3", bus.out_pc, 32'h100);
        checkOutput("rd_inst3", bus.out_inst, 32'h40);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("rd_pc4", bus.out_pc, 32'h104);
        checkOutput("rd_inst4", bus.out_inst, 32'h41);

        $display("[TB] redirect with handshake");
        doReset();
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("rh_pc0", bus.out_pc, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("rh_pc1", bus.out_pc, 32'h4);
        applyStimulus(1'b0, 1'b1, 32'h200, 1'b1);
        checkOutput("rh_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("rh_pc", bus.out_pc, 32'h8);
        checkOutput("rh_inst", bus.out_inst, 32'h2);
        checkOutput("rh_cs", 32'(bus.xbus_cs), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("rh_flush1", 32'(bus.out_valid), 32'd0);
        checkOutput("rh_addr", bus.xbus_addr, 32'h200);
        checkOutput("rh_cs1", 32'(bus.xbus_cs), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("rh_flush2", 32'(bus.out_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("rh_newpc", bus.out_pc, 32'h200);
        checkOutput("rh_newinst", bus.out_inst, 32'h80);

        $display("[TB] address wrap");
        doReset();
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        checkOutput("wr_cs0", 32'(bus.xbus_cs), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("wr_addr1", bus.xbus_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("wr_addr2", bus.xbus_addr, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("wr_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("wr_pc3", bus.out_pc, 32'hFFFF_FFFC);
        checkOutput("wr_inst3", bus.out_inst, 32'h3FFF_FFFF);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("wr_pc4", bus.out_pc, 32'h0);
        checkOutput("wr_inst4", bus.out_inst, 32'h0);

        $display("[TB] reset mid-operation");
        doReset();
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 1'b1, 32'h300, 1'b1);
            checkOutput("mr_cs", 32'(bus.xbus_cs), 32'd0);
            checkOutput("mr_valid", 32'(bus.out_valid), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("mr_cs0", 32'(bus.xbus_cs), 32'd1);
        checkOutput("mr_addr0", bus.xbus_addr, 32'h0);
        checkOutput("mr_valid0", 32'(bus.out_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("mr_valid1", 32'(bus.out_valid), 32'd0);
        checkOutput("mr_addr1", bus.xbus_addr, 32'h4);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("mr_valid2", 32'(bus.out_valid), 32'd1);
        checkOutput("mr_pc2", bus.out_pc, 32'h0);
        checkOutput("mr_inst2", bus.out_inst, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("mr_pc3", bus.out_pc, 32'h4);
        checkOutput("mr_inst3", bus.out_inst, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
